// File: rtl/pipe_credit_ctrl_if.sv
// Handshake bundle for pipe_credit_ctrl: block control, input stream,
// datapath issue/return and the result stream.
interface pipe_credit_ctrl_if #(
  parameter int DWIDTH = 12
);
  logic              start;
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              pipe_valid;
  logic [DWIDTH-1:0] pipe_din;
  logic [DWIDTH-1:0] pipe_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_last;

  // Controller side.
  modport master (
    input  start, in_valid, in_data, pipe_dout, out_ready,
    output busy, done, in_ready, pipe_valid, pipe_din, out_valid, out_data, out_last
  );

  // Environment side: source, datapath and sink.
  modport slave (
    output start, in_valid, in_data, pipe_dout, out_ready,
    input  busy, done, in_ready, pipe_valid, pipe_din, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pipe_credit_ctrl.sv
// Credit-based sequencer for one block of NUM_COEFFS coefficients through a
// fixed-latency, non-stallable datapath. Every issued coefficient holds a
// credit until its result leaves the result FIFO, so the FIFO cannot overflow.

// Invariant monitor for the result FIFO and the credit count.
module pipe_credit_ctrl_chk #(
  parameter int FIFO_DEPTH = 5,
  parameter int OW         = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          push_s,
  input logic          pop_s,
  input logic [OW-1:0] fifo_cnt_r,
  input logic [OW-1:0] occ_r
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_s && !pop_s && (fifo_cnt_r == OW'(FIFO_DEPTH))));

  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    occ_r <= OW'(FIFO_DEPTH));
endmodule

module pipe_credit_ctrl #(
  parameter int DWIDTH     = 12,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 5,
  parameter int NUM_COEFFS = 256
) (
  input logic                clk,
  input logic                rst,
  pipe_credit_ctrl_if.master bus
);
  localparam int CW = $clog2(NUM_COEFFS + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] NUM_C     = CW'(NUM_COEFFS);
  localparam logic [CW-1:0] LAST_C    = CW'(NUM_COEFFS - 1);
  localparam logic [OW-1:0] DEPTH_C   = OW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_MAX_C = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CW-1:0]     issued_r;
  logic [CW-1:0]     popped_r;
  logic [OW-1:0]     occ_r;
  logic [OW-1:0]     fifo_cnt_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [LAT-1:0]    vld_sr_r;
  logic [LAT-1:0]    vld_sr_nxt_s;
  logic [DWIDTH-1:0] mem_r [FIFO_DEPTH];

  logic in_ready_s;
  logic accept_s;
  logic push_s;
  logic out_valid_s;
  logic pop_s;
  logic start_run_s;

  // Circular pointer advance for a FIFO whose depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX_C) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Credits come only from registered occupancy, so out_ready never reaches in_ready.
  assign in_ready_s  = (state_r == ST_RUN) && (issued_r < NUM_C) && (occ_r < DEPTH_C);
  assign accept_s    = bus.in_valid && in_ready_s;
  assign push_s      = vld_sr_r[LAT-1];
  assign out_valid_s = (fifo_cnt_r != {OW{1'b0}});
  assign pop_s       = out_valid_s && bus.out_ready;
  assign start_run_s = (state_r == ST_IDLE) && bus.start;

  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.done       = (state_r == ST_DONE);
  assign bus.in_ready   = in_ready_s;
  assign bus.pipe_valid = accept_s;
  assign bus.pipe_din   = bus.in_data;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_data   = mem_r[rd_ptr_r];
  assign bus.out_last   = out_valid_s && (popped_r == LAST_C);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state: leave RUN on the final issue, leave DRAIN on the final pop.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) state_nxt_s = ST_RUN;
        else           state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && (issued_r == LAST_C)) state_nxt_s = ST_DRAIN;
        else                                  state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (pop_s && (popped_r == LAST_C)) state_nxt_s = ST_DONE;
        else                               state_nxt_s = ST_DRAIN;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Issue and pop counters, cleared when a block starts.
  always_ff @(posedge clk) begin
    if (rst || start_run_s) begin
      issued_r <= {CW{1'b0}};
      popped_r <= {CW{1'b0}};
    end else begin
      if (accept_s) issued_r <= issued_r + CW'(1);
      if (pop_s)    popped_r <= popped_r + CW'(1);
    end
  end

  // Credit occupancy: in-flight plus buffered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= {OW{1'b0}};
    end else begin
      case ({accept_s, pop_s})
        2'b10:   occ_r <= occ_r + OW'(1);
        2'b01:   occ_r <= occ_r - OW'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Next value of the validity shadow of the datapath.
  always_comb begin
    vld_sr_nxt_s    = {LAT{1'b0}};
    vld_sr_nxt_s[0] = accept_s;
    for (int i = 1; i < LAT; i++) begin
      vld_sr_nxt_s[i] = vld_sr_r[i-1];
    end
  end

  // Validity shadow register; clearing it discards whatever the datapath still holds.
  always_ff @(posedge clk) begin
    if (rst) vld_sr_r <= {LAT{1'b0}};
    else     vld_sr_r <= vld_sr_nxt_s;
  end

  // Result storage, written when a valid result leaves the datapath.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= bus.pipe_dout;
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      fifo_cnt_r <= {OW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + OW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - OW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  pipe_credit_ctrl_chk #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .OW         (OW)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .push_s     (push_s),
    .pop_s      (pop_s),
    .fifo_cnt_r (fifo_cnt_r),
    .occ_r      (occ_r)
  );
endmodule

// File: tb/tb_pipe_credit_ctrl.sv
// Randomized bench for pipe_credit_ctrl: a transaction-level reference model
// (credit arithmetic plus a queue of timestamped expected results) is checked
// every cycle against a default instance and a FIFO_DEPTH=2 instance.
module tb_pipe_credit_ctrl;
  localparam int DW   = 12;
  localparam int LAT  = 3;
  localparam int N    = 256;
  localparam int FD_A = 5;
  localparam int FD_B = 2;
  localparam int WIN  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_credit_ctrl_if #(.DWIDTH(DW)) bus_a ();
  pipe_credit_ctrl_if #(.DWIDTH(DW)) bus_b ();

  pipe_credit_ctrl #(.DWIDTH(DW), .LAT(LAT), .FIFO_DEPTH(FD_A), .NUM_COEFFS(N)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master));
  pipe_credit_ctrl #(.DWIDTH(DW), .LAT(LAT), .FIFO_DEPTH(FD_B), .NUM_COEFFS(N)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master));

  // Arbitrary datapath transform so results differ from the inputs.
  function automatic logic [DW-1:0] f_dp(input logic [DW-1:0] x);
    return x * 12'd5 + 12'h3A7;
  endfunction

  // Free-running LAT-stage datapaths; they keep shifting through reset.
  logic [DW-1:0] dp_a [LAT];
  logic [DW-1:0] dp_b [LAT];
  always @(posedge clk) begin
    dp_a[0] <= f_dp(bus_a.pipe_din);
    dp_b[0] <= f_dp(bus_b.pipe_din);
    for (int i = 1; i < LAT; i++) begin
      dp_a[i] <= dp_a[i-1];
      dp_b[i] <= dp_b[i-1];
    end
  end
  assign bus_a.pipe_dout = dp_a[LAT-1];
  assign bus_b.pipe_dout = dp_b[LAT-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct {
    logic [DW-1:0] val;
    int            t;
  } exp_t;
  exp_t exp_q[$];
  bit   use_b = 1'b0;
  int   cyc = 0;
  bit   m_busy = 1'b0;
  bit   m_done = 1'b0;
  int   m_acc = 0;
  int   m_pop = 0;

  // Observations per block.
  int obs_acc, obs_pop, obs_last, obs_done, first_acc, last_acc, first_ov, win_acc;

  task automatic drive(input bit st, input bit iv, input logic [DW-1:0] d, input bit ordy);
    bus_a.start = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    if (use_b) begin
      bus_b.start = st; bus_b.in_valid = iv; bus_b.in_data = d; bus_b.out_ready = ordy;
    end else begin
      bus_a.start = st; bus_a.in_valid = iv; bus_a.in_data = d; bus_a.out_ready = ordy;
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic tick(input bit st, input bit iv, input bit ordy);
    logic [DW-1:0] d, o_data;
    logic o_rdy, o_pv, o_ov, o_last, o_busy, o_done;
    bit m_rdy, m_ov, acc, pop;
    int fd;
    exp_t e;
    fd = use_b ? FD_B : FD_A;
    d  = DW'($urandom);
    drive(st, iv, d, ordy);
    #1;
    o_rdy  = use_b ? bus_b.in_ready   : bus_a.in_ready;
    o_pv   = use_b ? bus_b.pipe_valid : bus_a.pipe_valid;
    o_ov   = use_b ? bus_b.out_valid  : bus_a.out_valid;
    o_data = use_b ? bus_b.out_data   : bus_a.out_data;
    o_last = use_b ? bus_b.out_last   : bus_a.out_last;
    o_busy = use_b ? bus_b.busy       : bus_a.busy;
    o_done = use_b ? bus_b.done       : bus_a.done;

    m_rdy = m_busy && !m_done && (m_acc < N) && ((m_acc - m_pop) < fd);
    m_ov  = (exp_q.size() > 0) && (exp_q[0].t <= cyc);
    chk_eq("in_ready", 32'(o_rdy), 32'(m_rdy));
    chk_eq("pipe_valid", 32'(o_pv), 32'(iv && m_rdy));
    chk_eq("out_valid", 32'(o_ov), 32'(m_ov));
    if (m_ov) chk_eq("out_data", 32'(o_data), 32'(exp_q[0].val));
    chk_eq("out_last", 32'(o_last), 32'(m_ov && (m_pop == N - 1)));
    chk_eq("busy", 32'(o_busy), 32'(m_busy));
    chk_eq("done", 32'(o_done), 32'(m_done));

    if (o_pv) begin
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      obs_acc++;
      if (cyc < first_acc + WIN) win_acc++;
    end
    if (o_ov && first_ov < 0) first_ov = cyc;
    if (o_ov && ordy) obs_pop++;
    if (o_ov && ordy && o_last) obs_last++;
    if (o_done) obs_done++;

    acc = iv && m_rdy;
    pop = m_ov && ordy;
    @(posedge clk);
    if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (st) begin
        m_busy = 1'b1; m_acc = 0; m_pop = 0;
      end
    end else begin
      if (acc) begin
        e.val = f_dp(d); e.t = cyc + LAT + 1;
        exp_q.push_back(e);
        m_acc++;
      end
      if (pop) begin
        void'(exp_q.pop_front());
        m_pop++;
        if (m_pop == N) m_done = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    logic [6:0] outs;
    rst = 1'b1;
    drive(1'b0, 1'b1, DW'($urandom), 1'b1);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    exp_q.delete();
    m_busy = 1'b0; m_done = 1'b0; m_acc = 0; m_pop = 0;
    outs = use_b ? {bus_b.busy, bus_b.done, bus_b.in_ready, bus_b.pipe_valid,
                    bus_b.out_valid, bus_b.out_last, 1'b0}
                 : {bus_a.busy, bus_a.done, bus_a.in_ready, bus_a.pipe_valid,
                    bus_a.out_valid, bus_a.out_last, 1'b0};
    chk_eq("reset_outputs", 32'(outs), 32'(0));
    rst = 1'b0;
    // Stale datapath contents must never surface after reset.
    for (int i = 0; i < LAT + 3; i++) tick(1'b0, 1'b1, 1'b1);
  endtask

  // One block; hold > 0 keeps out_ready low for that many cycles after start.
  task automatic run_block(input int rdy_pct, input int vld_pct, input bit start_noise,
                           input int hold, input int abort_after);
    int  budget;
    bit  timed_out;
    bit  iv, ordy, st;
    obs_acc = 0; obs_pop = 0; obs_last = 0; obs_done = 0;
    first_acc = -1; last_acc = -1; first_ov = -1; win_acc = 0;
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < hold; i++) tick(1'b0, 1'b1, 1'b0);
    if (hold > 0) chk_eq("hold_accepts", 32'(obs_acc), 32'(use_b ? FD_B : FD_A));
    budget = 8000;
    timed_out = 1'b0;
    while (!m_done) begin
      if (abort_after > 0 && m_acc >= abort_after) return;
      if (budget == 0) begin
        timed_out = 1'b1;
        break;
      end
      budget--;
      iv   = ($urandom_range(99) < vld_pct);
      ordy = ($urandom_range(99) < rdy_pct);
      st   = start_noise && ($urandom_range(3) == 0);
      tick(st, iv, ordy);
    end
    chk_eq("block_timeout", 32'(timed_out), 32'(0));
    if (timed_out) return;
    tick(start_noise, 1'b1, 1'b1);   // DONE cycle
    chk_eq("n_accepts", 32'(obs_acc), 32'(N));
    chk_eq("n_pops", 32'(obs_pop), 32'(N));
    chk_eq("n_last", 32'(obs_last), 32'(1));
    chk_eq("n_done", 32'(obs_done), 32'(1));
  endtask

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk);
    do_reset();

    // 1. Full rate, always ready.
    run_block(100, 100, 1'b0, 0, 0);
    chk_eq("full_rate_span", 32'(last_acc - first_acc), 32'(N - 1));
    chk_eq("first_latency", 32'(first_ov - first_acc), 32'(LAT + 1));

    // 2. Sink stalled: credits limit accepts, outputs hold.
    run_block(50, 100, 1'b0, 20, 0);

    // 3. Random back-pressure, random input gaps.
    run_block(30, 80, 1'b0, 0, 0);

    // 5. Start noise during a block, back-to-back start right after DONE.
    run_block(70, 90, 1'b1, 0, 0);
    run_block(100, 100, 1'b0, 0, 0);

    // 6. Reset after 100 accepts, then a clean block.
    run_block(60, 100, 1'b0, 0, 100);
    do_reset();
    run_block(100, 100, 1'b0, 0, 0);

    // 4. Two credits with LAT=3: LAT+2 cycle credit round trip.
    use_b = 1'b1;
    do_reset();
    run_block(100, 100, 1'b0, 0, 0);
    chk_eq("throttle_window", 32'(win_acc), 32'(FD_B * (WIN / (LAT + 2))));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
